// File: rtl/hazard_ctrl.sv
// Hazard/interrupt controller: load-use and RAM2 stalls, branch check, sync interrupt entry.
// HAZARD_PERF_EN adds saturating stall/mispredict counters; otherwise they read 0.
module hazard_ctrl #(
  parameter int REG_AW     = 4,
  parameter int NSRC       = 2,
  parameter int LOAD_STALL = 1,
  parameter int PC_W       = 16,
  parameter int CNT_W      = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   int_req_i,
  input  logic                   ram2_conflict_i,
  input  logic                   ex_memread_i,
  input  logic                   ex_regwrite_i,
  input  logic [REG_AW-1:0]      ex_regdst_i,
  input  logic [NSRC*REG_AW-1:0] id_regsrc_i,
  input  logic [NSRC-1:0]        id_srcvalid_i,
  input  logic                   isjump_i,
  input  logic                   isbranch_i,
  input  logic                   ifbranch_i,
  input  logic                   prediction_i,
  input  logic [PC_W-1:0]        epc_i,
  output logic [PC_W-1:0]        epc_o,
  output logic                   int_taken_o,
  output logic                   stall_pc_o,
  output logic                   stall_if_o,
  output logic                   flush_if_o,
  output logic                   flush_id_o,
  output logic                   flush_ex_o,
  output logic                   jr_o,
  output logic                   prewrong_o,
  output logic                   precorrc_o,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [CNT_W-1:0]       mispred_cnt_o
);

  localparam int CNT_LW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
  localparam logic [CNT_LW-1:0] LS_INIT = CNT_LW'(LOAD_STALL - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_LDSTALL,
    S_INT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_LW-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [PC_W-1:0]   epc_q, epc_d;
  logic              lu_hit;
  logic              ld_stall;

  always_comb begin
    lu_hit = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (id_srcvalid_i[k] &&
          id_regsrc_i[k*REG_AW +: REG_AW] == ex_regdst_i)
        lu_hit = 1'b1;
    end
    lu_hit = lu_hit & ex_memread_i & ex_regwrite_i;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q | int_req_i;
    epc_d       = epc_q;
    ld_stall    = 1'b0;
    int_taken_o = 1'b0;
    stall_pc_o  = 1'b0;
    stall_if_o  = 1'b0;
    flush_if_o  = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    jr_o        = 1'b0;
    prewrong_o  = 1'b0;
    precorrc_o  = 1'b0;
    unique case (state_q)
      S_INT: begin
        int_taken_o = 1'b1;
        flush_if_o  = 1'b1;
        flush_id_o  = 1'b1;
        flush_ex_o  = 1'b1;
        state_d     = S_RUN;
      end
      S_LDSTALL: begin
        ld_stall = 1'b1;
        if (cnt_q == CNT_LW'(1)) state_d = S_RUN;
        else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        ld_stall = lu_hit;
        if (lu_hit && LOAD_STALL > 1) begin
          state_d = S_LDSTALL;
          cnt_d   = LS_INIT;
        end
      end
    endcase
    if (state_q != S_INT) begin
      // RAM2 owns the fetch port: drop the fetched word instead of holding it
      stall_pc_o = ld_stall | ram2_conflict_i;
      stall_if_o = ld_stall & ~ram2_conflict_i;
      flush_id_o = ld_stall;
      jr_o       = isjump_i & ~stall_pc_o;
      prewrong_o = isbranch_i & (prediction_i ^ ifbranch_i) & ~stall_pc_o;
      precorrc_o = isbranch_i & ~(prediction_i ^ ifbranch_i) & ~stall_pc_o;
      flush_if_o = ram2_conflict_i | prewrong_o | jr_o;
      if (state_q == S_RUN && pend_q && !stall_pc_o) begin
        state_d = S_INT;
        pend_d  = 1'b0;
        epc_d   = epc_i;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      epc_q   <= epc_d;
    end
  end

  assign epc_o = epc_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] scnt_q, mcnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (stall_pc_o && !(&scnt_q)) scnt_q <= scnt_q + 1'b1;
      if (prewrong_o && !(&mcnt_q)) mcnt_q <= mcnt_q + 1'b1;
    end
  end

  assign stall_cnt_o   = scnt_q;
  assign mispred_cnt_o = mcnt_q;
`else
  assign stall_cnt_o   = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_STALL=1 and 3) on shared stimulus,
// checked each cycle against a cycle-level model plus literal expectations.
module tb_hazard_ctrl;

  logic        CLK, RST;
  logic        int_req, ram2, memrd, regwr;
  logic [3:0]  regdst;
  logic [7:0]  regsrc;
  logic [1:0]  srcvld;
  logic        isjump, isbranch, ifbranch, pred;
  logic [15:0] epc_in;

  logic [15:0] epc_o [2];
  logic [1:0]  scnt [2];
  logic [1:0]  mcnt [2];
  logic        it [2], spc [2], sif [2], fif [2], fid [2];
  logic        fex [2], jr [2], pw [2], pc [2];

  int nchecks = 0;
  int nerr = 0;

  hazard_ctrl #(.LOAD_STALL(1), .CNT_W(2)) u1 (
    .CLK(CLK), .RST(RST), .int_req_i(int_req), .ram2_conflict_i(ram2),
    .ex_memread_i(memrd), .ex_regwrite_i(regwr), .ex_regdst_i(regdst),
    .id_regsrc_i(regsrc), .id_srcvalid_i(srcvld), .isjump_i(isjump),
    .isbranch_i(isbranch), .ifbranch_i(ifbranch), .prediction_i(pred),
    .epc_i(epc_in), .epc_o(epc_o[0]), .int_taken_o(it[0]),
    .stall_pc_o(spc[0]), .stall_if_o(sif[0]), .flush_if_o(fif[0]),
    .flush_id_o(fid[0]), .flush_ex_o(fex[0]), .jr_o(jr[0]),
    .prewrong_o(pw[0]), .precorrc_o(pc[0]),
    .stall_cnt_o(scnt[0]), .mispred_cnt_o(mcnt[0])
  );

  hazard_ctrl #(.LOAD_STALL(3), .CNT_W(2)) u3 (
    .CLK(CLK), .RST(RST), .int_req_i(int_req), .ram2_conflict_i(ram2),
    .ex_memread_i(memrd), .ex_regwrite_i(regwr), .ex_regdst_i(regdst),
    .id_regsrc_i(regsrc), .id_srcvalid_i(srcvld), .isjump_i(isjump),
    .isbranch_i(isbranch), .ifbranch_i(ifbranch), .prediction_i(pred),
    .epc_i(epc_in), .epc_o(epc_o[1]), .int_taken_o(it[1]),
    .stall_pc_o(spc[1]), .stall_if_o(sif[1]), .flush_if_o(fif[1]),
    .flush_id_o(fid[1]), .flush_ex_o(fex[1]), .jr_o(jr[1]),
    .prewrong_o(pw[1]), .precorrc_o(pc[1]),
    .stall_cnt_o(scnt[1]), .mispred_cnt_o(mcnt[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // model state, index 0 = LOAD_STALL 1, index 1 = LOAD_STALL 3
  int          m_rem [2];
  bit          m_pend [2];
  bit          m_int [2];
  logic [15:0] m_epc [2];
  int          m_sc [2];
  int          m_mc [2];

  always @(negedge CLK) begin
    logic [8:0] ec, ac;
    bit lu, busy, lus, st, ej, ep, ek;
    int es, em;
    for (int u = 0; u < 2; u++) begin
      ac = {it[u], spc[u], sif[u], fif[u], fid[u], fex[u], jr[u], pw[u], pc[u]};
      if (RST) begin
        m_rem[u] = 0; m_pend[u] = 0; m_int[u] = 0;
        m_epc[u] = '0; m_sc[u] = 0; m_mc[u] = 0;
        chk($sformatf("rst_ctl_u%0d", u), 32'(ac), 32'd0);
        chk($sformatf("rst_epc_u%0d", u), 32'(epc_o[u]), 32'd0);
        chk($sformatf("rst_cnt_u%0d", u), 32'({scnt[u], mcnt[u]}), 32'd0);
      end else begin
`ifdef HAZARD_PERF_EN
        es = m_sc[u]; em = m_mc[u];
`else
        es = 0; em = 0;
`endif
        chk($sformatf("epc_u%0d", u), 32'(epc_o[u]), 32'(m_epc[u]));
        chk($sformatf("scnt_u%0d", u), 32'(scnt[u]), 32'(es));
        chk($sformatf("mcnt_u%0d", u), 32'(mcnt[u]), 32'(em));
        lu = memrd && regwr &&
             ((srcvld[0] && regsrc[3:0] == regdst) ||
              (srcvld[1] && regsrc[7:4] == regdst));
        if (m_int[u]) begin
          ec = 9'b1_0_0_1_1_1_0_0_0;
          m_int[u] = 0;
          m_pend[u] = m_pend[u] | int_req;
          st = 0; ep = 0;
        end else begin
          busy = m_rem[u] > 0;
          lus  = busy || lu;
          st   = lus || ram2;
          ej   = isjump && !st;
          ep   = isbranch && (pred != ifbranch) && !st;
          ek   = isbranch && (pred == ifbranch) && !st;
          ec   = {1'b0, st, lus && !ram2, ram2 || ej || ep, lus, 1'b0, ej, ep, ek};
          if (busy) m_rem[u] = m_rem[u] - 1;
          else if (lu) m_rem[u] = (u == 0) ? 0 : 2;
          if (m_pend[u] && !st) begin
            m_int[u] = 1; m_pend[u] = 0; m_epc[u] = epc_in;
          end else m_pend[u] = m_pend[u] | int_req;
        end
        chk($sformatf("ctl_u%0d", u), 32'(ac), 32'(ec));
        if (st && m_sc[u] < 3) m_sc[u]++;
        if (ep && m_mc[u] < 3) m_mc[u]++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    int_req = 0; ram2 = 0; memrd = 0; regwr = 0; regdst = 0;
    regsrc = 0; srcvld = 0; isjump = 0; isbranch = 0;
    ifbranch = 0; pred = 0;
  endtask

  task automatic load_r3();
    memrd = 1; regwr = 1; regdst = 4'd3;
    regsrc = 8'h03; srcvld = 2'b01;
  endtask

  initial begin
    RST = 1; epc_in = 16'h0042;
    idle();
    tick();
    chk("lit_rst_epc", 32'(epc_o[0]), 32'h0);
    tick();
    RST = 0;
    repeat (2) tick();

    load_r3();
    #1 chk("t1_stall", 32'({spc[0], sif[0], fid[0], fif[0]}), 32'b1110);
    tick();
    idle();
    #1 chk("t1_release", 32'(spc[0]), 32'd0);
    tick();
    load_r3(); srcvld = 2'b10;
    #1 chk("t1_noval", 32'(spc[0]), 32'd0);
    tick();
    idle();
    repeat (4) tick();

    for (int i = 0; i < 4; i++) begin
      if (i == 0) load_r3(); else idle();
      isjump = 1;
      #1;
      chk("t2_jr", 32'(jr[1]), (i == 3) ? 32'd1 : 32'd0);
      chk("t2_stall", 32'({spc[1], fid[1]}), (i < 3) ? 32'b11 : 32'b00);
      tick();
    end
    idle();
    repeat (3) tick();

    load_r3(); ram2 = 1;
    #1 chk("t3_both", 32'({spc[0], fif[0], fid[0]}), 32'b111);
    tick();
    idle();
    #1 chk("t3_one", 32'(spc[0]), 32'd0);
    tick();
    repeat (4) tick();

    isbranch = 1; pred = 1; ifbranch = 0;
    #1 chk("t4_wrong", 32'({pw[0], fif[0], pc[0]}), 32'b110);
    tick();
    ifbranch = 1;
    #1 chk("t4_corr", 32'({pw[0], fif[0], pc[0]}), 32'b001);
    tick();
    idle();
    repeat (2) tick();

    load_r3();
    tick();
    idle(); int_req = 1;
    tick();
    int_req = 0;
    tick();
    #1 chk("t5_u3_wait", 32'(it[1]), 32'd0);
    chk("t5_u1_int", 32'(it[0]), 32'd1);
    tick();
    #1 chk("t5_u3_int", 32'({it[1], fif[1], fid[1], fex[1]}), 32'hF);
    chk("t5_u3_epc", 32'(epc_o[1]), 32'h42);
    tick();
    repeat (3) tick();

    RST = 1;
    tick();
    RST = 0;
    ram2 = 1;
    repeat (5) tick();
    ram2 = 0;
`ifdef HAZARD_PERF_EN
    #1 chk("t6_sat", 32'(scnt[0]), 32'd3);
`else
    #1 chk("t6_sat", 32'(scnt[0]), 32'd0);
`endif
    tick();
    int_req = 1;
    tick();
    int_req = 0;
    tick();
    #1 chk("t6_int", 32'(it[0]), 32'd1);
    RST = 1;
    #1 chk("t6_rst_ctl", 32'({it[0], spc[0], fif[0], fid[0], fex[0]}), 32'd0);
    chk("t6_rst_cnt", 32'({scnt[0], mcnt[0], epc_o[0]}), 32'd0);
    tick();
    RST = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
